// File: rtl/bnn_conv_pe.sv
// Binary convolution processing element.
// Holds one KxKxCIN binary kernel, slides it over a streamed frame of tap
// columns with stride S, and emits either the signed XNOR-popcount sum
// (2*popcount - N) or its comparison against a signed threshold.
// Fixed three-stage pipeline: window update, XNOR register, popcount/output.
module bnn_conv_pe #(
   parameter int  K    = 3,
   parameter int  CIN  = 1,
   parameter int  S    = 1,
   parameter int  MAXW = 32,
   localparam int N    = K*K*CIN,
   localparam int SW   = $clog2(N+1)+1,
   localparam int IW   = $clog2(MAXW+1),
   localparam int TW   = K*CIN
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 w_load,
   input  logic                 w_valid,
   input  logic                 w_bit,
   output logic                 w_done,
   input  logic                 start,
   input  logic [IW-1:0]        img_w,
   input  logic [IW-1:0]        img_h,
   input  logic                 bin_mode,
   input  logic signed [SW-1:0] thresh,
   input  logic                 in_valid,
   input  logic [TW-1:0]        in_taps,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic signed [SW-1:0] out_sum,
   output logic                 out_bit,
   output logic                 busy,
   output logic                 done,
   output logic [2:0]           dbg_state
);

   localparam int PW  = (N > 1) ? $clog2(N) : 1;
   localparam int PCW = SW - 1;
   localparam int SPW = (S > 1) ? $clog2(S) : 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [N-1:0]         w_q;
   logic [PW-1:0]        ptr_q;
   logic                 w_done_q;
   logic [IW-1:0]        img_w_q, img_h_q, x_q, y_q;
   logic [SPW-1:0]       xp_q, yp_q;
   logic                 bin_q;
   logic signed [SW-1:0] thresh_q;
   logic [K-1:0][TW-1:0] win_q, win_d;
   logic [N-1:0]         win_flat, xnor_q;
   logic                 c1_v_q, c2_v_q;
   logic                 out_valid_q, out_bit_q;
   logic signed [SW-1:0] out_sum_q, sum_c;
   logic [PCW-1:0]       pc;
   logic                 accept, row_end, last_beat, emit, start_go, small_frame;

   // Tap handshake: a column transfers on every rising edge where in_valid and
   // in_ready are both high; in_ready is high exactly while in RUN, and the
   // upstream must hold in_taps stable while in_valid is high and in_ready low.
   assign in_ready    = (state_q == ST_RUN);
   assign accept      = in_valid & in_ready;
   assign row_end     = (x_q == img_w_q - IW'(1));
   assign last_beat   = accept & row_end & (y_q == img_h_q - IW'(K));
   // xp/yp are stride phases; zero marks a column/row where a window lands.
   assign emit        = accept & (x_q >= IW'(K-1)) & (xp_q == '0) & (yp_q == '0);
   assign start_go    = (state_q == ST_IDLE) & start & w_done_q & ~w_load;
   assign small_frame = (img_w < IW'(K)) | (img_h < IW'(K));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; a frame too small for one window goes straight to drain.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (w_load)        state_d = ST_LOAD;
            else if (start_go) state_d = small_frame ? ST_DRAIN : ST_RUN;
         end
         ST_LOAD:  if (!w_load && w_valid && ptr_q == PW'(N-1)) state_d = ST_IDLE;
         ST_RUN:   if (last_beat) state_d = ST_DRAIN;
         ST_DRAIN: if (!c1_v_q && !c2_v_q) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Kernel load: w_load restarts the pointer, the N-th bit sets w_done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_q      <= '0;
         ptr_q    <= '0;
         w_done_q <= 1'b0;
      end else if (w_load && (state_q == ST_IDLE || state_q == ST_LOAD)) begin
         ptr_q    <= '0;
         w_done_q <= 1'b0;
      end else if (state_q == ST_LOAD && w_valid) begin
         w_q[ptr_q] <= w_bit;
         ptr_q      <= ptr_q + PW'(1);
         if (ptr_q == PW'(N-1)) w_done_q <= 1'b1;
      end
   end

   // Frame configuration capture and x/y position plus stride-phase tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         img_w_q  <= '0;
         img_h_q  <= '0;
         bin_q    <= 1'b0;
         thresh_q <= '0;
         x_q      <= '0;
         y_q      <= '0;
         xp_q     <= '0;
         yp_q     <= '0;
      end else if (start_go) begin
         img_w_q  <= img_w;
         img_h_q  <= img_h;
         bin_q    <= bin_mode;
         thresh_q <= thresh;
         x_q      <= '0;
         y_q      <= '0;
         xp_q     <= '0;
         yp_q     <= '0;
      end else if (accept) begin
         if (row_end) begin
            x_q  <= '0;
            xp_q <= '0;
            y_q  <= y_q + IW'(1);
            yp_q <= (yp_q == SPW'(S-1)) ? '0 : yp_q + SPW'(1);
         end else begin
            x_q <= x_q + IW'(1);
            if (x_q >= IW'(K-1)) xp_q <= (xp_q == SPW'(S-1)) ? '0 : xp_q + SPW'(1);
         end
      end
   end

   // Window shift: newest column enters at K-1; older columns drop at row start.
   always_comb begin
      win_d = win_q;
      if (accept) begin
         for (int c = 0; c < K-1; c++) win_d[c] = (x_q == '0) ? '0 : win_q[c+1];
         win_d[K-1] = in_taps;
      end
   end

   // Stage 1: window register and its emit flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_q  <= '0;
         c1_v_q <= 1'b0;
      end else begin
         win_q  <= win_d;
         c1_v_q <= emit;
      end
   end

   // Reorder window into kernel order (row, col, channel; channel fastest).
   always_comb begin
      win_flat = '0;
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++)
            for (int ch = 0; ch < CIN; ch++)
               win_flat[(r*K+c)*CIN+ch] = win_q[c][(K-1-r)*CIN+ch];
   end

   // Stage 2: XNOR of window against kernel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xnor_q <= '0;
         c2_v_q <= 1'b0;
      end else begin
         if (c1_v_q) xnor_q <= ~(win_flat ^ w_q);
         c2_v_q <= c1_v_q;
      end
   end

   // Popcount and mapping to 2*pc-N; modular SW-bit arithmetic is exact here.
   always_comb begin
      pc = '0;
      for (int i = 0; i < N; i++) pc = pc + PCW'(xnor_q[i]);
      sum_c = $signed({pc, 1'b0} - SW'(N));
   end

   // Stage 3: result register; idle cycles drive zeros.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_bit_q   <= 1'b0;
      end else begin
         out_valid_q <= c2_v_q;
         if (c2_v_q) begin
            out_sum_q <= bin_q ? '0 : sum_c;
            out_bit_q <= bin_q & (sum_c >= thresh_q);
         end else begin
            out_sum_q <= '0;
            out_bit_q <= 1'b0;
         end
      end
   end

   assign w_done    = w_done_q;
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_bit   = out_bit_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_bnn_conv_pe.sv
// Bench for bnn_conv_pe with K=3, CIN=2, S=2: directed frames with
// hand-known results plus reference-convolution frames, checked through an
// expected-value queue drained by an output monitor.
module tb_bnn_conv_pe;

   localparam int K    = 3;
   localparam int CIN  = 2;
   localparam int S    = 2;
   localparam int MAXW = 32;
   localparam int N    = K*K*CIN;
   localparam int SW   = $clog2(N+1)+1;
   localparam int IW   = $clog2(MAXW+1);
   localparam int TW   = K*CIN;
   localparam int OW   = SW+1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 w_load, w_valid, w_bit, w_done;
   logic                 start;
   logic [IW-1:0]        img_w, img_h;
   logic                 bin_mode;
   logic signed [SW-1:0] thresh;
   logic                 in_valid;
   logic [TW-1:0]        in_taps;
   logic                 in_ready, out_valid, out_bit, busy, done;
   logic signed [SW-1:0] out_sum;
   logic [2:0]           dbg_state;

   logic [N-1:0]   kern;
   logic [CIN-1:0] img [MAXW][MAXW];
   logic [OW-1:0]  exp_q[$];
   int             lat_q[$];
   int             n_vec = 0, n_err = 0;
   int             cyc = 0, out_cnt = 0, done_cnt = 0;
   logic [OW-1:0]  mon_e;
   int             mon_l;

   bnn_conv_pe #(.K(K), .CIN(CIN), .S(S), .MAXW(MAXW)) dut (
      .clk(clk), .rst(rst),
      .w_load(w_load), .w_valid(w_valid), .w_bit(w_bit), .w_done(w_done),
      .start(start), .img_w(img_w), .img_h(img_h), .bin_mode(bin_mode), .thresh(thresh),
      .in_valid(in_valid), .in_taps(in_taps), .in_ready(in_ready),
      .out_valid(out_valid), .out_sum(out_sum), .out_bit(out_bit),
      .busy(busy), .done(done), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int model_sum(input int oy, input int ox);
      int pc;
      pc = 0;
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++)
            for (int ch = 0; ch < CIN; ch++)
               if (kern[(r*K+c)*CIN+ch] == img[oy+r][ox+c][ch]) pc++;
      return 2*pc - N;
   endfunction

   function automatic logic [OW-1:0] exp_word(input int s, input bit bin, input int thr);
      logic [SW-1:0] sv;
      sv = SW'(s);
      if (bin) return {((s >= thr) ? 1'b1 : 1'b0), {SW{1'b0}}};
      return {1'b0, sv};
   endfunction

   // mode 0 all-1, 1 all-0, 2 checkerboard, 3 inverted checkerboard, else random
   task automatic fill_image(input int mode);
      for (int y = 0; y < MAXW; y++)
         for (int x = 0; x < MAXW; x++)
            case (mode)
               0:       img[y][x] = {CIN{1'b1}};
               1:       img[y][x] = {CIN{1'b0}};
               2:       img[y][x] = ((x+y)%2 != 0) ? {CIN{1'b1}} : {CIN{1'b0}};
               3:       img[y][x] = ((x+y)%2 != 0) ? {CIN{1'b0}} : {CIN{1'b1}};
               default: img[y][x] = CIN'($urandom_range(0, (1<<CIN)-1));
            endcase
   endtask

   // ---------------- drivers ----------------
   task automatic load_kernel(input logic [N-1:0] k, input bit gaps);
      @(negedge clk);
      w_load = 1'b1;
      @(negedge clk);
      w_load = 1'b0;
      check("w_done_cleared", w_done, 0);
      for (int p = 0; p < N; p++) begin
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
         w_valid = 1'b1;
         w_bit   = k[p];
         @(negedge clk);
         w_valid = 1'b0;
      end
      check("w_done_set", w_done, 1);
      kern = k;
   endtask

   task automatic run_frame(input int w, input int h, input bit bin, input int thr,
                            input bit gaps, input int abort_at, input int wl_at,
                            input bit use_hand, input int hand);
      int            beats, exp_cnt, cnt0, dn0, t, s;
      bit            emitb;
      logic [TW-1:0] taps;
      beats   = 0;
      exp_cnt = (w < K || h < K) ? 0 : ((w-K)/S+1)*((h-K)/S+1);
      cnt0    = out_cnt;
      dn0     = done_cnt;
      @(negedge clk);
      start = 1'b1; img_w = IW'(w); img_h = IW'(h); bin_mode = bin; thresh = SW'(thr);
      @(negedge clk);
      // frame settings are captured at start; scramble them afterwards
      start = 1'b0; img_w = IW'($urandom); img_h = IW'($urandom);
      bin_mode = ~bin; thresh = SW'($urandom);
      check("busy_after_start", busy, 1);
      if (w >= K && h >= K) begin
         for (int y = 0; y <= h-K; y++) begin
            for (int x = 0; x < w; x++) begin
               if (abort_at >= 0 && beats == abort_at) return;
               if (gaps) repeat ($urandom_range(0, 2)) begin
                  in_taps = TW'($urandom);
                  @(negedge clk);
               end
               taps = '0;
               for (int r = 0; r < K; r++) taps[(K-1-r)*CIN +: CIN] = img[y+r][x];
               emitb    = (x >= K-1) && ((x-(K-1)) % S == 0) && (y % S == 0);
               in_valid = 1'b1;
               in_taps  = taps;
               if (beats == wl_at) w_load = 1'b1;
               t = 0;
               while (!in_ready && t < 20) begin
                  @(negedge clk);
                  t++;
               end
               if (!in_ready) check("in_ready_timeout", in_ready, 1);
               else if (emitb) begin
                  s = use_hand ? hand : model_sum(y, x-(K-1));
                  exp_q.push_back(exp_word(s, bin, thr));
                  lat_q.push_back(cyc + 3);
               end
               @(negedge clk);
               in_valid = 1'b0;
               w_load   = 1'b0;
               beats++;
            end
         end
      end
      t = 0;
      while (done_cnt == dn0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      check("done_pulses", done_cnt - dn0, 1);
      check("frame_out_count", out_cnt - cnt0, exp_cnt);
      check("busy_after_done", busy, 0);
   endtask

   task automatic mid_reset();
      #2 rst = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sum", out_sum, 0);
      check("rst_w_done", w_done, 0);
      check("rst_busy", busy, 0);
      exp_q.delete();
      lat_q.delete();
      in_valid = 1'b0;
      w_load   = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
               check("unexpected_out", {out_bit, out_sum}, 0);
            end else begin
               mon_e = exp_q.pop_front();
               mon_l = lat_q.pop_front();
               check("out_value", {out_bit, out_sum}, mon_e);
               check("out_latency", cyc, mon_l);
            end
         end
         if (done) begin
            done_cnt++;
            check("done_no_overlap", out_valid, 0);
            check("done_after_all_out", exp_q.size(), 0);
         end
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic [N-1:0] ck, rk;
      int           dn_before;
      rst = 1'b1; w_load = 1'b0; w_valid = 1'b0; w_bit = 1'b0; start = 1'b0;
      img_w = '0; img_h = '0; bin_mode = 1'b0; thresh = '0; in_valid = 1'b0; in_taps = '0;
      kern = '0;
      repeat (3) @(negedge clk);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_sum", out_sum, 0);
      check("reset_out_bit", out_bit, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_w_done", w_done, 0);
      check("reset_in_ready", in_ready, 0);
      rst = 1'b0;
      @(negedge clk);

      // start without a kernel is ignored
      start = 1'b1; img_w = IW'(5); img_h = IW'(5);
      @(negedge clk);
      start = 1'b0;
      check("busy_no_weights", busy, 0);
      check("in_ready_no_weights", in_ready, 0);

      // all-ones kernel; a surplus weight bit must not land anywhere
      load_kernel({N{1'b1}}, 1'b1);
      w_valid = 1'b1; w_bit = 1'b0;
      @(negedge clk);
      w_valid = 1'b0;
      check("w_done_after_extra", w_done, 1);

      fill_image(0);
      run_frame(28, 28, 0, 0, 0, -1, -1, 1, 18);     // 169 outputs of +18
      fill_image(1);
      run_frame(13, 13, 0, 0, 0, -1, -1, 1, -18);    // 36 outputs of -18
      run_frame(13, 13, 1, 0, 0, -1, -1, 1, -18);    // bit 0
      run_frame(5, 5, 1, -18, 0, -1, -1, 1, -18);    // -18 >= -18 -> bit 1
      fill_image(0);
      run_frame(9, 9, 1, 18, 0, -1, -1, 1, 18);      // 18 >= 18 -> bit 1
      run_frame(5, 5, 1, 19, 0, -1, -1, 1, 18);      // 18 < 19 -> bit 0

      // checkerboard kernel against aligned / inverted checkerboards
      ck = '0;
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++)
            for (int ch = 0; ch < CIN; ch++)
               ck[(r*K+c)*CIN+ch] = ((r+c)%2 != 0);
      load_kernel(ck, 1'b0);
      fill_image(2);
      run_frame(7, 7, 0, 0, 0, -1, -1, 1, 18);
      fill_image(3);
      run_frame(7, 7, 0, 0, 0, -1, -1, 1, -18);

      // random kernel and pixels, valid gaps, w_load pulsed during RUN
      rk = N'({$urandom, $urandom});
      load_kernel(rk, 1'b1);
      fill_image(4);
      run_frame(11, 9, 0, 0, 1, -1, 30, 0, 0);
      check("w_done_kept_after_run_wload", w_done, 1);
      fill_image(4);
      run_frame(8, 10, 1, 2, 0, -1, -1, 0, 0);

      // frames smaller than the kernel: no outputs, one done
      run_frame(2, 10, 0, 0, 0, -1, -1, 0, 0);
      run_frame(10, 2, 0, 0, 0, -1, -1, 0, 0);

      // reset in the middle of a row, then a full restart
      fill_image(4);
      dn_before = done_cnt;
      run_frame(11, 9, 0, 0, 0, 9, -1, 0, 0);
      mid_reset();
      repeat (4) @(negedge clk);
      check("no_done_after_abort", done_cnt - dn_before, 0);
      start = 1'b1; img_w = IW'(11); img_h = IW'(9);
      @(negedge clk);
      start = 1'b0;
      check("busy_after_rst_start", busy, 0);
      load_kernel(rk, 1'b0);
      run_frame(11, 9, 0, 0, 1, -1, -1, 0, 0);

      repeat (5) @(negedge clk);
      check("exp_queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
